// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the writeback stage.
//   REG_BUS_W / REG_ADDR_W : register-file data and address widths
//   ld_size_e              : load-size encodings (byte/half/word/dword)
//   EBREAK_INST            : instruction word that halts the core on commit
//   wb_state_e             : writeback control states
package wb_stage_pkg;

    localparam int unsigned REG_BUS_W  = 64;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: combinational load-data formatter.
//   rdata       in  : aligned doubleword from data memory
//   off         in  : byte offset within the doubleword
//   size        in  : access size (byte/half/word/dword)
//   is_unsigned in  : zero-extend instead of sign-extend (ignored for dword)
//   data        out : shifted, extended load result
//   misaligned  out : offset not naturally aligned for the access size
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  ld_size_e        size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh         = rdata >> {off, 3'b000};
        data       = sh;
        misaligned = 1'b0;
        case (size)
            LD_B: begin
                data = is_unsigned ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                   : {{(XLEN-8){sh[7]}}, sh[7:0]};
            end
            LD_H: begin
                data       = is_unsigned ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                         : {{(XLEN-16){sh[15]}}, sh[15:0]};
                misaligned = off[0];
            end
            LD_W: begin
                data       = is_unsigned ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                         : {{(XLEN-32){sh[31]}}, sh[31:0]};
                misaligned = (off[1:0] != 2'b00);
            end
            LD_D: begin
                data       = sh;
                misaligned = (off != 3'b000);
            end
            default: begin
                data       = sh;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage, one-entry MEM/WB register with valid/ready.
//   clk, rst (async, active-low)
//   mem_valid_i / mem_ready_o         : handshake with MEM stage
//   mem_pc_i, mem_inst_i              : instruction identity
//   mem_rd_we_i, mem_rd_i             : destination register control
//   mem_alu_res_i                     : non-load result
//   mem_is_load_i, mem_ld_size_i,
//   mem_ld_unsigned_i, mem_ld_off_i,
//   mem_rdata_i                       : load formatting inputs
//   stall_i                           : downstream holds commit
//   we_o, waddr_o, wdata_o            : register-file write port
//   commit_valid_o, commit_pc_o,
//   commit_inst_o, instret_o          : difftest commit information
//   misalign_o                        : retiring load was misaligned
//   halt_o                            : sticky, ebreak committed
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN        = REG_BUS_W,
    parameter logic [31:0] EBREAK_INST = wb_stage_pkg::EBREAK_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [XLEN-1:0]       mem_pc_i,
    input  logic [31:0]           mem_inst_i,
    input  logic                  mem_rd_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]       mem_alu_res_i,
    input  logic                  mem_is_load_i,
    input  logic [1:0]            mem_ld_size_i,
    input  logic                  mem_ld_unsigned_i,
    input  logic [2:0]            mem_ld_off_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  stall_i,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  commit_valid_o,
    output logic [XLEN-1:0]       commit_pc_o,
    output logic [31:0]           commit_inst_o,
    output logic [XLEN-1:0]       instret_o,
    output logic                  misalign_o,
    output logic                  halt_o
);

    wb_state_e             state;
    wb_state_e             state_next;

    logic                  wb_valid;
    logic [XLEN-1:0]       wb_pc;
    logic [31:0]           wb_inst;
    logic                  wb_rd_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_wdata;
    logic                  wb_mis;
    logic [XLEN-1:0]       instret;

    logic [XLEN-1:0]       ext_data;
    logic                  ext_mis;
    logic                  fire;
    logic                  capture;

    wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata       (mem_rdata_i),
        .off         (mem_ld_off_i),
        .size        (ld_size_e'(mem_ld_size_i)),
        .is_unsigned (mem_ld_unsigned_i),
        .data        (ext_data),
        .misaligned  (ext_mis)
    );

    assign fire = wb_valid & ~stall_i & (state == WB_RUN);

    // Gated with rst so the stage never advertises ready while held in reset.
    assign mem_ready_o = rst & (state == WB_RUN) & (~wb_valid | fire);
    assign capture     = mem_valid_i & mem_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WB_RUN:  if (fire && (wb_inst == EBREAK_INST)) state_next = WB_HALT;
            WB_HALT: state_next = WB_HALT;
            default: state_next = WB_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_pc    <= '0;
            wb_inst  <= '0;
            wb_rd_we <= 1'b0;
            wb_rd    <= '0;
            wb_wdata <= '0;
            wb_mis   <= 1'b0;
        end else if (capture) begin
            wb_valid <= 1'b1;
            wb_pc    <= mem_pc_i;
            wb_inst  <= mem_inst_i;
            wb_rd_we <= mem_rd_we_i;
            wb_rd    <= mem_rd_i;
            wb_wdata <= mem_is_load_i ? ext_data : mem_alu_res_i;
            wb_mis   <= mem_is_load_i & ext_mis;
        end else if (fire) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (fire) begin
            instret <= instret + 1'b1;
        end
    end

    assign we_o           = fire & wb_rd_we & (wb_rd != '0) & ~wb_mis;
    assign waddr_o        = wb_rd;
    assign wdata_o        = wb_wdata;
    assign commit_valid_o = fire;
    assign commit_pc_o    = wb_pc;
    assign commit_inst_o  = wb_inst;
    assign instret_o      = instret;
    assign misalign_o     = fire & wb_mis;
    assign halt_o         = (state == WB_HALT);

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [63:0] mem_pc_i;
    logic [31:0] mem_inst_i;
    logic        mem_rd_we_i;
    logic [4:0]  mem_rd_i;
    logic [63:0] mem_alu_res_i;
    logic        mem_is_load_i;
    logic [1:0]  mem_ld_size_i;
    logic        mem_ld_unsigned_i;
    logic [2:0]  mem_ld_off_i;
    logic [63:0] mem_rdata_i;
    logic        stall_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [31:0] commit_inst_o;
    logic [63:0] instret_o;
    logic        misalign_o;
    logic        halt_o;

    int checks = 0;
    int errors = 0;

    wb_stage #(
        .XLEN        (64),
        .EBREAK_INST (32'h0010_0073)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid_i       (mem_valid_i),
        .mem_ready_o       (mem_ready_o),
        .mem_pc_i          (mem_pc_i),
        .mem_inst_i        (mem_inst_i),
        .mem_rd_we_i       (mem_rd_we_i),
        .mem_rd_i          (mem_rd_i),
        .mem_alu_res_i     (mem_alu_res_i),
        .mem_is_load_i     (mem_is_load_i),
        .mem_ld_size_i     (mem_ld_size_i),
        .mem_ld_unsigned_i (mem_ld_unsigned_i),
        .mem_ld_off_i      (mem_ld_off_i),
        .mem_rdata_i       (mem_rdata_i),
        .stall_i           (stall_i),
        .we_o              (we_o),
        .waddr_o           (waddr_o),
        .wdata_o           (wdata_o),
        .commit_valid_o    (commit_valid_o),
        .commit_pc_o       (commit_pc_o),
        .commit_inst_o     (commit_inst_o),
        .instret_o         (instret_o),
        .misalign_o        (misalign_o),
        .halt_o            (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                           input logic rwe, input logic [4:0] rd, input logic [63:0] alu,
                           input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [2:0] off, input logic [63:0] rdata);
        mem_valid_i       = v;
        mem_pc_i          = pc;
        mem_inst_i        = inst;
        mem_rd_we_i       = rwe;
        mem_rd_i          = rd;
        mem_alu_res_i     = alu;
        mem_is_load_i     = ld;
        mem_ld_size_i     = sz;
        mem_ld_unsigned_i = uns;
        mem_ld_off_i      = off;
        mem_rdata_i       = rdata;
    endtask

    task automatic idle();
        present(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
    endtask

    initial begin
        rst     = 1'b0;
        stall_i = 1'b0;
        idle();
        #2;
        chk("rst_ready",   {63'b0, mem_ready_o},    64'd0);
        chk("rst_we",      {63'b0, we_o},           64'd0);
        chk("rst_commit",  {63'b0, commit_valid_o}, 64'd0);
        chk("rst_instret", instret_o,               64'd0);
        chk("rst_halt",    {63'b0, halt_o},         64'd0);
        chk("rst_wdata",   wdata_o,                 64'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("ready_after_rst", {63'b0, mem_ready_o}, 64'd1);

        // ld x5, dword, off 0
        present(1'b1, 64'h100, 32'h0000_3283, 1'b1, 5'd5, 64'h0, 1'b1, 2'd3, 1'b0, 3'd0,
                64'h8000_0000_0000_0001);
        tick();
        idle();
        #1;
        chk("ld_we",      {63'b0, we_o},           64'd1);
        chk("ld_waddr",   {59'b0, waddr_o},        64'd5);
        chk("ld_wdata",   wdata_o,                 64'h8000_0000_0000_0001);
        chk("ld_commit",  {63'b0, commit_valid_o}, 64'd1);
        chk("ld_pc",      commit_pc_o,             64'h100);
        chk("ld_instret_before", instret_o,        64'd0);
        tick();
        chk("ld_instret_after", instret_o,         64'd1);
        chk("ld_idle_commit", {63'b0, commit_valid_o}, 64'd0);

        // lb x6, off 3 (sign-extend 0xF0)
        present(1'b1, 64'h104, 32'h0030_0303, 1'b1, 5'd6, 64'h0, 1'b1, 2'd0, 1'b0, 3'd3,
                64'h0000_0000_F000_0000);
        tick();
        idle();
        #1;
        chk("lb_wdata", wdata_o,        64'hFFFF_FFFF_FFFF_FFF0);
        chk("lb_we",    {63'b0, we_o},  64'd1);
        tick();

        // lbu x7, same data
        present(1'b1, 64'h108, 32'h0030_4383, 1'b1, 5'd7, 64'h0, 1'b1, 2'd0, 1'b1, 3'd3,
                64'h0000_0000_F000_0000);
        tick();
        idle();
        #1;
        chk("lbu_wdata", wdata_o, 64'h0000_0000_0000_00F0);
        tick();
        chk("lbu_instret", instret_o, 64'd3);

        // lw x8, off 2 -> misaligned, retires without writing
        present(1'b1, 64'h10C, 32'h0020_2403, 1'b1, 5'd8, 64'h0, 1'b1, 2'd2, 1'b0, 3'd2,
                64'h1234_5678_9ABC_DEF0);
        tick();
        idle();
        #1;
        chk("lw_commit",   {63'b0, commit_valid_o}, 64'd1);
        chk("lw_misalign", {63'b0, misalign_o},     64'd1);
        chk("lw_we",       {63'b0, we_o},           64'd0);
        tick();
        chk("lw_instret",  instret_o, 64'd4);

        // ALU x1 stalled for three cycles, then ALU x0 back-to-back
        present(1'b1, 64'h200, 32'h0010_0093, 1'b1, 5'd1, 64'h1111, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
        tick();
        present(1'b1, 64'h204, 32'h0020_0013, 1'b1, 5'd0, 64'h2222, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_we",     {63'b0, we_o},           64'd0);
            chk("stall_commit", {63'b0, commit_valid_o}, 64'd0);
            chk("stall_ready",  {63'b0, mem_ready_o},    64'd0);
            chk("stall_waddr",  {59'b0, waddr_o},        64'd1);
            chk("stall_wdata",  wdata_o,                 64'h1111);
            if (i < 2) tick();
            else @(posedge clk);
        end
        #1;
        stall_i = 1'b0;
        #1;
        chk("x1_we",     {63'b0, we_o},        64'd1);
        chk("x1_waddr",  {59'b0, waddr_o},     64'd1);
        chk("x1_wdata",  wdata_o,              64'h1111);
        chk("x1_ready",  {63'b0, mem_ready_o}, 64'd1);
        tick();
        idle();
        #1;
        chk("x0_we",     {63'b0, we_o},           64'd0);
        chk("x0_commit", {63'b0, commit_valid_o}, 64'd1);
        chk("x0_pc",     commit_pc_o,             64'h204);
        tick();
        chk("x0_instret", instret_o, 64'd6);
        chk("x0_empty_we", {63'b0, we_o}, 64'd0);

        // ebreak commits and halts; following addi is never accepted
        present(1'b1, 64'h300, 32'h0010_0073, 1'b0, 5'd0, 64'h0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
        tick();
        idle();
        #1;
        chk("ebreak_commit", {63'b0, commit_valid_o}, 64'd1);
        chk("ebreak_inst",   {32'b0, commit_inst_o},  64'h0010_0073);
        chk("ebreak_halt_pre", {63'b0, halt_o},       64'd0);
        tick();
        present(1'b1, 64'h304, 32'h0010_0093, 1'b1, 5'd1, 64'h5555, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_flag",    {63'b0, halt_o},         64'd1);
            chk("halt_ready",   {63'b0, mem_ready_o},    64'd0);
            chk("halt_commit",  {63'b0, commit_valid_o}, 64'd0);
            chk("halt_we",      {63'b0, we_o},           64'd0);
            chk("halt_instret", instret_o,               64'd7);
            tick();
        end

        // Reset clears halt; then reset again while an instruction is held
        idle();
        rst = 1'b0;
        #1;
        chk("rst2_halt", {63'b0, halt_o}, 64'd0);
        tick();
        rst = 1'b1;
        #1;
        present(1'b1, 64'h400, 32'h0050_0293, 1'b1, 5'd5, 64'h7777, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
        tick();
        idle();
        stall_i = 1'b1;
        #1;
        chk("held_waddr", {59'b0, waddr_o}, 64'd5);
        rst = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("midrst_we",      {63'b0, we_o},           64'd0);
        chk("midrst_commit",  {63'b0, commit_valid_o}, 64'd0);
        chk("midrst_instret", instret_o,               64'd0);
        chk("midrst_waddr",   {59'b0, waddr_o},        64'd0);
        chk("midrst_wdata",   wdata_o,                 64'd0);
        chk("midrst_pc",      commit_pc_o,             64'd0);
        chk("midrst_ready",   {63'b0, mem_ready_o},    64'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_ready",  {63'b0, mem_ready_o},    64'd1);
        chk("post_rst_commit", {63'b0, commit_valid_o}, 64'd0);
        tick();
        chk("post_rst_instret", instret_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
